// File: rtl/button_press_ctrl_if.sv
// Bundles the raw button inputs, the repeat-mode enable and all per-channel
// button event outputs of button_press_ctrl.
interface button_press_ctrl_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] button;
  logic            repeat_en;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] short_pulse;
  logic [N_CH-1:0] long_pulse;
  logic [N_CH-1:0] longpush;
  logic [N_CH-1:0] repeat_pulse;

  modport master (
    output button, repeat_en,
    input  level, press_pulse, short_pulse, long_pulse, longpush, repeat_pulse
  );

  modport slave (
    input  button, repeat_en,
    output level, press_pulse, short_pulse, long_pulse, longpush, repeat_pulse
  );
endinterface

// File: rtl/button_press_ctrl.sv
// Per-channel button conditioner: 2-flop synchroniser, debounce, and a
// short/long/auto-repeat press classifier. All outputs are registered.
module button_press_ctrl #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int LONG_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input logic               clk,
  input logic               rst,
  button_press_ctrl_if.slave bus
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] short_vec;
  logic [N_CH-1:0] long_vec;
  logic [N_CH-1:0] longpush_vec;
  logic [N_CH-1:0] repeat_vec;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic          sync1_reg, sync2_reg;
      logic          level_reg, level_next;
      logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
      logic          accept, rise, fall;
      state_t        state_reg, state_next;
      logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
      logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
      logic          press_reg, press_next;
      logic          short_reg, short_next;
      logic          long_reg, long_next;
      logic          longpush_reg, longpush_next;
      logic          repeat_reg, repeat_next;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= bus.button[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // The FSM sees the level change on the same edge that commits it, so
      // press_pulse lines up with the rising edge of level.
      assign accept = (sync2_reg != level_reg) && (deb_cnt_reg == DEB_LAST);
      assign rise   = accept & sync2_reg;
      assign fall   = accept & ~sync2_reg;

      always_comb begin
        level_next   = level_reg;
        deb_cnt_next = '0;
        if (sync2_reg != level_reg) begin
          if (deb_cnt_reg == DEB_LAST) begin
            level_next = sync2_reg;
          end else begin
            deb_cnt_next = deb_cnt_reg + DW'(1);
          end
        end
      end

      always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        rep_cnt_next  = rep_cnt_reg;
        press_next    = 1'b0;
        short_next    = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;
        case (state_reg)
          IDLE: begin
            hold_cnt_next = '0;
            rep_cnt_next  = '0;
            if (rise) begin
              state_next = PRESSED;
              press_next = 1'b1;
            end
          end
          PRESSED: begin
            if (fall) begin
              state_next = IDLE;
              short_next = 1'b1;
            end else if (hold_cnt_reg == HOLD_LAST) begin
              state_next   = LONG;
              long_next    = 1'b1;
              rep_cnt_next = '0;
            end else begin
              hold_cnt_next = hold_cnt_reg + HW'(1);
            end
          end
          LONG: begin
            if (fall) begin
              state_next = IDLE;
            end else if (!bus.repeat_en) begin
              rep_cnt_next = '0;
            end else if (rep_cnt_reg == REP_LAST) begin
              rep_cnt_next = '0;
              repeat_next  = 1'b1;
            end else begin
              rep_cnt_next = rep_cnt_reg + RW'(1);
            end
          end
          default: state_next = IDLE;
        endcase
        longpush_next = (state_next == LONG);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          level_reg    <= 1'b0;
          deb_cnt_reg  <= '0;
          state_reg    <= IDLE;
          hold_cnt_reg <= '0;
          rep_cnt_reg  <= '0;
          press_reg    <= 1'b0;
          short_reg    <= 1'b0;
          long_reg     <= 1'b0;
          longpush_reg <= 1'b0;
          repeat_reg   <= 1'b0;
        end else begin
          level_reg    <= level_next;
          deb_cnt_reg  <= deb_cnt_next;
          state_reg    <= state_next;
          hold_cnt_reg <= hold_cnt_next;
          rep_cnt_reg  <= rep_cnt_next;
          press_reg    <= press_next;
          short_reg    <= short_next;
          long_reg     <= long_next;
          longpush_reg <= longpush_next;
          repeat_reg   <= repeat_next;
        end
      end

      assign level_vec[gi]    = level_reg;
      assign press_vec[gi]    = press_reg;
      assign short_vec[gi]    = short_reg;
      assign long_vec[gi]     = long_reg;
      assign longpush_vec[gi] = longpush_reg;
      assign repeat_vec[gi]   = repeat_reg;
    end
  endgenerate

  assign bus.level        = level_vec;
  assign bus.press_pulse  = press_vec;
  assign bus.short_pulse  = short_vec;
  assign bus.long_pulse   = long_vec;
  assign bus.longpush     = longpush_vec;
  assign bus.repeat_pulse = repeat_vec;
endmodule

// File: doc/button_press_ctrl.md
BUTTON_PRESS_CTRL -- requirements
Module: button_press_ctrl

Interface
REQ-001 Parameter N_CH, default 4, number of independent button channels (1..16).
REQ-002 Parameter DEB_CYCLES, default 4, consecutive stable synchronised cycles required to accept a level change (>=1).
REQ-003 Parameter LONG_CYCLES, default 16, debounced-high cycles after press at which a press becomes long (>DEB_CYCLES).
REQ-004 Parameter REPEAT_CYCLES, default 8, auto-repeat period in cycles once long (>=1).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 button  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 repeat_en  input  1  global auto-repeat mode enable, sampled every cycle.
REQ-009 level  output  N_CH  debounced button level.
REQ-010 press_pulse  output  N_CH  one-cycle pulse on debounced press.
REQ-011 short_pulse  output  N_CH  one-cycle pulse on release of a press that never became long.
REQ-012 long_pulse  output  N_CH  one-cycle pulse when a press becomes long.
REQ-013 longpush  output  N_CH  high while a long press is held.
REQ-014 repeat_pulse  output  N_CH  one-cycle auto-repeat pulse.

Function
REQ-015 Each channel SHALL be fully independent; all outputs registered; bit i depends only on button[i], repeat_en, clk, rst.
REQ-016 Each channel SHALL pass button[i] through a 2-flop synchroniser; output s.
REQ-017 Debounce: counter clears when s == level; increments when s != level; when counter == DEB_CYCLES-1 and s != level, level <= s and counter clears.
REQ-018 Press-to-level latency SHALL be DEB_CYCLES+2 edges, counting the first edge sampling button high; release identical.
REQ-019 Any mismatch shorter than DEB_CYCLES cycles SHALL leave level unchanged.
REQ-020 Per-channel FSM states: IDLE, PRESSED, LONG.
REQ-021 IDLE: on level rise -> PRESSED, press_pulse high that same cycle, hold counter cleared.
REQ-022 PRESSED: hold counter increments per cycle; on count == LONG_CYCLES-1 with level still high -> LONG, long_pulse high, repeat counter cleared.
REQ-023 PRESSED: level fall -> IDLE, short_pulse high one cycle.
REQ-024 LONG: longpush high; level fall -> IDLE, longpush low next cycle, no short_pulse.
REQ-025 LONG with repeat_en=1: repeat counter increments; at REPEAT_CYCLES-1 it wraps to 0 and repeat_pulse fires; first repeat_pulse REPEAT_CYCLES cycles after long_pulse.
REQ-026 LONG with repeat_en=0: repeat counter held at 0, no repeat_pulse; re-enabling restarts a full period.
REQ-027 Counters SHALL be sized $clog2 of their limit and never wrap in PRESSED (LONG transition occurs first).
REQ-028 At most one of press_pulse, short_pulse, long_pulse, repeat_pulse per channel per cycle.

Reset
REQ-029 rst high SHALL immediately clear synchronisers, counters, FSM to IDLE, and all outputs to 0 regardless of clk.
REQ-030 After rst release a button already held SHALL be treated as a new press (press_pulse after DEB_CYCLES+2 edges).
REQ-031 Reset mid-press SHALL emit no short_pulse or long_pulse.

Verification (N_CH=2, DEB_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8)
REQ-032 rst high, button=2'b11 -> all outputs 0; release rst -> level[1:0]=11 and press_pulse=11 on 6th edge.
REQ-033 button[0] high 3 cycles then low -> level, all pulses stay 0.
REQ-034 button[0] high 10 cycles -> press_pulse once, level high 10 cycles, short_pulse once on level fall, long_pulse/longpush never.
REQ-035 button[0] high 40 cycles, repeat_en=0 -> long_pulse 16 cycles after press_pulse, longpush high until level falls, no short_pulse, no repeat_pulse.
REQ-036 Same with repeat_en=1 -> repeat_pulse at 8 and 16 cycles after long_pulse, stopping at release; button[1] toggled concurrently produces only its own pulses.
REQ-037 rst pulsed 5 cycles after long_pulse while held -> longpush 0 immediately, no short_pulse; new press_pulse 6 edges after rst release.
